// File: rtl/window_pkg.sv
// Shared types and sizing helpers for the overlapped-window sequencer.
package window_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FILL     = 2'd1,
    RUN      = 2'd2,
    WAIT_ACK = 2'd3
  } win_state_e;

  localparam int STAT_W = 16;

  function automatic int WINDOW_LEN(input int aw);
    return 1 << aw;
  endfunction

  // Half a window minus one sample is replayed at the start of the next pass.
  function automatic int REWIND(input int aw);
    return (1 << (aw - 1)) - 1;
  endfunction

endpackage

// File: rtl/window_sequencer_if.sv
// Strobe/status bundle between the sequencer and the window address manager.
interface window_sequencer_if;
  logic enqueue;
  logic dequeue;
  logic full;
  logic empty;
  logic last;

  modport master (output enqueue, dequeue, input full, empty, last);
  modport slave  (input enqueue, dequeue, output full, empty, last);
endinterface

// File: rtl/window_level_counter.sv
// Tracks samples readable in the current pass and flags when a window can start.
module window_level_counter
  import window_pkg::*;
#(
  parameter int ADDRWIDTH = 12,
  parameter int REWIND    = window_pkg::REWIND(ADDRWIDTH)
) (
  input  logic clock,
  input  logic reset_n,
  input  logic wr,
  input  logic rd,
  input  logic last,
  input  logic first_window,
  output logic thresh_met
);

  localparam int LW = ADDRWIDTH + 1;
  localparam logic [LW-1:0] RW_L   = LW'(REWIND);
  localparam logic [LW-1:0] FULL_L = LW'(WINDOW_LEN(ADDRWIDTH));
  localparam logic [LW-1:0] OVLP_L = LW'(WINDOW_LEN(ADDRWIDTH) - REWIND);

  logic [LW-1:0] level;
  logic [LW-1:0] level_next;

  // Completing a window hands the overlap back to the read side.
  assign level_next = level + LW'(wr) - LW'(rd) + ((rd && last) ? RW_L : '0);

  // Compared on the updated count so the write that reaches threshold starts RUN next cycle.
  assign thresh_met = first_window ? (level_next >= FULL_L) : (level_next >= OVLP_L);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      level <= '0;
    end else begin
      level <= level_next;
    end
  end

endmodule

// File: rtl/window_sequencer.sv
// Sequencer between the audio stream, window FIFO address manager and FFT front end.
// Define WINDOW_SEQUENCER_STATS_EN to build the frame/drop statistics counters.
module window_sequencer
  import window_pkg::*;
#(
  parameter int ADDRWIDTH = 12,
  parameter int REWIND    = window_pkg::REWIND(ADDRWIDTH)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               in_valid,
  output logic               in_ready,
  window_sequencer_if.master fifo,
  input  logic               fft_ready,
  input  logic               frame_done,
  output logic               out_valid,
  output logic               out_first,
  output logic               out_last,
  output logic               busy,
  output logic               overrun,
  output logic [STAT_W-1:0]  frame_count,
  output logic [STAT_W-1:0]  drop_count
);

  // state    | meaning
  // IDLE     | stopped, waiting for enable
  // FILL     | buffering until a window's worth is readable
  // RUN      | streaming one window of reads to the FFT
  // WAIT_ACK | window issued, waiting for frame_done

  win_state_e state, state_next;
  logic dequeue;
  logic drop_evt;
  logic first_window;
  logic first_pending;
  logic enter_run;
  logic win_done;
  logic thresh_met;

  // Gated by reset_n so every output reads 0 while reset is held.
  assign in_ready     = reset_n && enable && !fifo.full;
  assign fifo.enqueue = in_valid && in_ready;
  assign fifo.dequeue = dequeue;
  assign drop_evt     = in_valid && enable && fifo.full;
  assign busy         = (state != IDLE);
  assign win_done     = dequeue && fifo.last;
  assign enter_run    = (state == FILL) && (state_next == RUN);

  window_level_counter #(
    .ADDRWIDTH (ADDRWIDTH),
    .REWIND    (REWIND)
  ) u_level (
    .clock        (clock),
    .reset_n      (reset_n),
    .wr           (fifo.enqueue),
    .rd           (dequeue),
    .last         (fifo.last),
    .first_window (first_window),
    .thresh_met   (thresh_met)
  );

  always_comb begin
    state_next = state;
    dequeue    = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_next = FILL;
      end
      FILL: begin
        if (!enable)         state_next = IDLE;
        else if (thresh_met) state_next = RUN;
      end
      RUN: begin
        dequeue = fft_ready && !fifo.empty;
        if (dequeue && fifo.last) state_next = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (frame_done) state_next = enable ? FILL : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      first_window  <= 1'b1;
      first_pending <= 1'b0;
      out_valid     <= 1'b0;
      out_first     <= 1'b0;
      out_last      <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next == IDLE) first_window <= 1'b1;
      else if (win_done)      first_window <= 1'b0;
      if (enter_run)    first_pending <= 1'b1;
      else if (dequeue) first_pending <= 1'b0;
      out_valid <= dequeue;
      out_first <= dequeue && first_pending;
      out_last  <= dequeue && fifo.last;
      if (drop_evt) overrun <= 1'b1;
    end
  end

`ifdef WINDOW_SEQUENCER_STATS_EN
  logic [STAT_W-1:0] frame_cnt;
  logic [STAT_W-1:0] drop_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if ((state == WAIT_ACK) && frame_done) frame_cnt <= frame_cnt + STAT_W'(1);
      if (drop_evt)                          drop_cnt  <= drop_cnt + STAT_W'(1);
    end
  end

  assign frame_count = frame_cnt;
  assign drop_count  = drop_cnt;
`else
  assign frame_count = '0;
  assign drop_count  = '0;
`endif

endmodule

// File: tb/tb_window_sequencer.sv
// Directed bench for window_sequencer (N=16) with a cycle model and a mock address manager.
module tb_window_sequencer;

  localparam int AW = 4;
  localparam int N  = 16;
  localparam int RW = 7;
`ifdef WINDOW_SEQUENCER_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  localparam int M_IDLE = 0, M_FILL = 1, M_RUN = 2, M_WAIT = 3;

  logic clock, reset_n, enable, in_valid, in_ready, fft_ready, frame_done;
  logic out_valid, out_first, out_last, busy, overrun;
  logic [15:0] frame_count, drop_count;

  window_sequencer_if fifo_bus ();

  window_sequencer #(.ADDRWIDTH(AW)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .enable      (enable),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .fifo        (fifo_bus),
    .fft_ready   (fft_ready),
    .frame_done  (frame_done),
    .out_valid   (out_valid),
    .out_first   (out_first),
    .out_last    (out_last),
    .busy        (busy),
    .overrun     (overrun),
    .frame_count (frame_count),
    .drop_count  (drop_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Mock address manager: occ = samples held in RAM, rd_idx = position inside current window.
  int occ, rd_idx;
  bit force_full;

  task automatic drive_mock();
    fifo_bus.full  = force_full || (occ >= N);
    fifo_bus.empty = (occ == rd_idx);
    fifo_bus.last  = (rd_idx == N - 1);
  endtask

  bit s_enq, s_deq, s_ov, s_of, s_ol, s_busy;

  task automatic cyc();
    @(negedge clock);
    s_enq = fifo_bus.enqueue; s_deq = fifo_bus.dequeue;
    s_ov = out_valid; s_of = out_first; s_ol = out_last; s_busy = busy;
    @(posedge clock);
    #1;
    if (!reset_n) begin
      occ = 0; rd_idx = 0;
    end else begin
      if (s_enq) occ++;
      if (s_deq) begin
        if (rd_idx == N - 1) begin rd_idx = 0; occ -= (N - RW); end
        else rd_idx++;
      end
    end
    drive_mock();
  endtask

  // Behavioural model: mode and readable count as plain integers, checked every falling edge.
  int m_mode, m_level;
  bit m_first_win, m_pend, m_ov, m_of, m_ol, m_overrun;
  int m_frames, m_drops;

  always @(negedge clock) begin
    bit e_rdy, e_enq, e_deq, drop;
    int lvl;
    if (!reset_n) begin
      m_mode = M_IDLE; m_level = 0; m_first_win = 1; m_pend = 0;
      m_ov = 0; m_of = 0; m_ol = 0; m_overrun = 0; m_frames = 0; m_drops = 0;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out_valid", out_valid, 0);
    end else begin
      e_rdy = enable && !fifo_bus.full;
      e_enq = in_valid && e_rdy;
      e_deq = (m_mode == M_RUN) && fft_ready && !fifo_bus.empty;
      chk("m_in_ready", in_ready, e_rdy);
      chk("m_enqueue", fifo_bus.enqueue, e_enq);
      chk("m_dequeue", fifo_bus.dequeue, e_deq);
      chk("m_out_valid", out_valid, m_ov);
      chk("m_out_first", out_first, m_of);
      chk("m_out_last", out_last, m_ol);
      chk("m_busy", busy, m_mode != M_IDLE);
      chk("m_overrun", overrun, m_overrun);
      chk("m_frame_count", frame_count, STATS ? (m_frames % 65536) : 0);
      chk("m_drop_count", drop_count, STATS ? (m_drops % 65536) : 0);

      lvl  = m_level + int'(e_enq) - int'(e_deq) + ((e_deq && fifo_bus.last) ? RW : 0);
      drop = in_valid && enable && !e_rdy;
      if (drop) begin m_overrun = 1; m_drops++; end
      m_ov = e_deq;
      m_ol = e_deq && fifo_bus.last;
      m_of = e_deq && m_pend;
      if (e_deq) m_pend = 0;
      case (m_mode)
        M_IDLE: if (enable) m_mode = M_FILL;
        M_FILL: begin
          if (!enable) m_mode = M_IDLE;
          else if (lvl >= (m_first_win ? N : N - RW)) begin m_mode = M_RUN; m_pend = 1; end
        end
        M_RUN:  if (e_deq && fifo_bus.last) begin m_mode = M_WAIT; m_first_win = 0; end
        default: if (frame_done) begin m_frames++; m_mode = enable ? M_FILL : M_IDLE; end
      endcase
      if (m_mode == M_IDLE) m_first_win = 1;
      if (lvl < 0) chk("level_nonneg", lvl, 0);
      m_level = lvl;
    end
  end

  task automatic startup();
    int nd;
    nd = 0;
    enable = 1; in_valid = 1; fft_ready = 1;
    for (int i = 0; i < 15; i++) begin cyc(); nd += int'(s_deq); end
    chk("fill15_no_dequeue", nd, 0);
    chk("fill15_busy", s_busy, 1);
    cyc(); chk("write16_no_dequeue_yet", s_deq, 0);
    in_valid = 0;
    cyc(); chk("dequeue_after_16th", s_deq, 1); chk("first_not_early", s_of, 0);
    cyc(); chk("out_first_after_dequeue", s_of, 1); chk("out_valid_first", s_ov, 1);
  endtask

  // One window period; frame_done follows out_last by 2 cycles.
  task automatic run_window(input bit toggle, input bit en_drop,
                            output int nv, output int nl, output int nf, output int ncons);
    int last_at;
    bit done, prev_v;
    nv = 0; nl = 0; nf = 0; ncons = 0; last_at = -10; done = 0; prev_v = 0;
    for (int k = 0; k < 300; k++) begin
      in_valid   = 1;
      fft_ready  = toggle ? k[0] : 1'b1;
      frame_done = (k == last_at + 2);
      if (en_drop && nv == 10) enable = 0;
      cyc();
      if (s_ov) nv++;
      if (s_ov && prev_v) ncons++;
      prev_v = s_ov;
      if (s_of) nf++;
      if (s_ol) begin nl++; last_at = k; end
      if (frame_done) begin done = 1; break; end
    end
    frame_done = 0;
    chk("window_completed", done, 1);
  endtask

  task automatic do_reset();
    reset_n = 0; in_valid = 0; fft_ready = 0; frame_done = 0; force_full = 0;
    occ = 0; rd_idx = 0; drive_mock();
    cyc(); cyc();
    reset_n = 1;
  endtask

  int nv, nl, nf, nc;

  initial begin
    clock = 0; reset_n = 0; enable = 0; in_valid = 0; fft_ready = 0; frame_done = 0;
    force_full = 0; occ = 0; rd_idx = 0; drive_mock();
    #3;
    chk("reset_busy", busy, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_overrun", overrun, 0);
    chk("reset_frame_count", frame_count, 0);
    cyc(); cyc();
    reset_n = 1;

    startup();
    run_window(0, 0, nv, nl, nf, nc);
    chk("w1_out_last_once", nl, 1);
    run_window(0, 0, nv, nl, nf, nc);
    chk("w2_valid16", nv, 16); chk("w2_last_once", nl, 1); chk("w2_first_once", nf, 1);
    run_window(0, 0, nv, nl, nf, nc);
    chk("w3_valid16", nv, 16); chk("w3_last_once", nl, 1);
    chk("frame_count_3", frame_count, STATS ? 3 : 0);

    run_window(1, 0, nv, nl, nf, nc);
    chk("bp_valid16", nv, 16); chk("bp_last_once", nl, 1); chk("bp_no_back_to_back", nc, 0);

    run_window(0, 1, nv, nl, nf, nc);
    chk("drop_last_seen", nl, 1); chk("drop_valid16", nv, 16);
    in_valid = 0;
    cyc(); chk("drop_idle_busy", s_busy, 0);

    do_reset();
    enable = 1; force_full = 1; drive_mock(); in_valid = 1;
    cyc(); cyc(); cyc();
    in_valid = 0; force_full = 0; drive_mock();
    cyc();
    chk("overrun_set", overrun, 1);
    chk("drop_count_3", drop_count, STATS ? 3 : 0);

    do_reset();
    enable = 1; in_valid = 1; fft_ready = 1;
    for (int i = 0; i < 16; i++) cyc();
    in_valid = 0;
    for (int i = 0; i < 5; i++) cyc();
    chk("pre_reset_running", s_busy, 1);
    #2 reset_n = 0;
    #1;
    chk("async_busy", busy, 0);
    chk("async_dequeue", fifo_bus.dequeue, 0);
    chk("async_out_valid", out_valid, 0);
    chk("async_in_ready", in_ready, 0);
    occ = 0; rd_idx = 0; drive_mock();
    cyc();
    reset_n = 1;
    startup();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/window_sequencer.md
# window_sequencer

Control sequencer for the overlapped-window sample FIFO. It sits between the incoming audio sample stream and the FFT front end, and drives the window address manager's `enqueue`/`dequeue` strobes. Writes are admitted from the audio stream. A window's worth of reads is released to the FFT only once enough samples are buffered. Completion of each frame is handshaked with the FFT. Read data from the window RAM arrives one cycle after `fifo_dequeue`, and `out_valid`/`out_first`/`out_last` are aligned to it.

## Interface
- `ADDRWIDTH`, default 12: FIFO address width; window length N = 2^ADDRWIDTH.
- `REWIND`, default 2^(ADDRWIDTH-1)-1: samples re-exposed to the read side when a window completes.
- `clock` input, 1 bit: single clock; all state updates on its rising edge.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `enable` input, 1 bit: run request.
- `in_valid` input, 1 bit: audio sample present this cycle (the stream cannot stall).
- `in_ready` output, 1 bit: sample will be written.
- `fifo_enqueue` output, 1 bit: write strobe to the address manager.
- `fifo_dequeue` output, 1 bit: read strobe to the address manager.
- `fifo_full` input, 1 bit: address manager full.
- `fifo_empty` input, 1 bit: address manager empty.
- `fifo_last` input, 1 bit: the current read is window index N-1.
- `fft_ready` input, 1 bit: FFT accepts a sample next cycle.
- `frame_done` input, 1 bit: one-cycle pulse when the FFT has consumed the frame.
- `out_valid` output, 1 bit: RAM read data valid this cycle.
- `out_first` output, 1 bit: first sample of a window.
- `out_last` output, 1 bit: last sample of a window.
- `busy` output, 1 bit: state is not IDLE.
- `overrun` output, 1 bit: sticky flag; a sample was dropped.
- `frame_count` output, 16 bits: completed windows (see Configuration).
- `drop_count` output, 16 bits: dropped samples (see Configuration).

## Operation
- **Reset values.** All outputs are 0. State is IDLE and `level` is 0.
- **`level`** is ADDRWIDTH+1 bits and counts samples readable in the current pass.
  - `level' = level + wr - rd + ((rd && fifo_last) ? REWIND : 0)`.
  - `wr = fifo_enqueue` and `rd = fifo_dequeue`.
- **Write side (combinational):**
  - `in_ready = enable && !fifo_full`.
  - `fifo_enqueue = in_valid && in_ready`.
  - When `in_valid && !in_ready && enable`, set `overrun` and increment `drop_count`.
  - `overrun` is cleared only by reset.
- **IDLE.** Go to FILL when `enable` is high.
- **FILL.**
  - Go to RUN when `level >= N` on the first window, or `level >= N-REWIND` on later windows.
  - If `enable` is low, go to IDLE.
- **RUN.**
  - `fifo_dequeue = fft_ready && !fifo_empty`.
  - A dequeue with `fifo_last` high moves to WAIT_ACK.
  - `enable` falling during RUN does not abort; the window completes.
- **WAIT_ACK.**
  - No dequeues are issued.
  - On `frame_done`, increment `frame_count`, then go to FILL if `enable` is high, otherwise IDLE.
  - A `frame_done` seen in any other state is ignored.
- **Leaving IDLE** clears the "first window" flag only after the first window completes. The flag is set again on every entry to IDLE.

## Timing
- `out_valid`, `out_first` and `out_last` are registered and trail `fifo_dequeue` by exactly 1 cycle.
- `out_first` marks the first dequeue after entering RUN.
- `out_last` equals `fifo_last` at the dequeue, delayed by 1 cycle.
- Throughput: one sample per cycle while `fft_ready` is held high. A window takes N RUN cycles minimum.
- FILL to RUN takes 1 cycle after the threshold is met.
- WAIT_ACK to FILL takes 1 cycle after `frame_done`.
- Simultaneous write and read in one cycle: both are applied, and `level` nets them.
- `fifo_empty` in RUN stalls the read without leaving RUN. It cannot occur when `level` is correct; treat it as a defensive guard.
- Asynchronous reset mid-window: returns to IDLE immediately. The address manager is reset by the same `reset_n`.

## Configuration
- `WINDOW_SEQUENCER_STATS_EN` defined: the 16-bit wrapping `frame_count` and `drop_count` registers are present.
- Not defined: both outputs are tied to 0 and no counter flops exist.
- `overrun` is always present in both cases.

## Structure
- Shared package `window_pkg` holds:
  - the state enum (IDLE, FILL, RUN, WAIT_ACK), 2 bits;
  - `WINDOW_LEN(ADDRWIDTH)` and `REWIND(ADDRWIDTH)` constants/functions;
  - the 16-bit stat width.
- One natural sub-module, `window_level_counter`: `level` update plus threshold compare. Everything else stays in a single module.

## Test plan
- **Reset and start-up.** ADDRWIDTH=4, N=16, `enable`=1, write 15 samples -> state stays FILL with no dequeue. Write the 16th sample -> `fifo_dequeue` on the next cycle and `out_first` one cycle after that.
- **Steady overlap.** Continuous input, `fft_ready`=1, `frame_done` pulsed 2 cycles after `out_last` -> second window starts once `level >= 9`. `frame_count` reaches 3 after 3 windows. `level` is never negative.
- **Backpressure.** Toggle `fft_ready` every cycle in RUN -> exactly 16 `out_valid` pulses per window. Gaps match `fft_ready` low cycles and `out_last` appears only once.
- **Overrun.** Hold `fifo_full`=1 with `in_valid`=1 for 3 cycles -> `overrun`=1 and `drop_count`=3 with STATS_EN defined, 0 without it.
- **Enable drop.** Deassert `enable` mid-RUN -> the window finishes and `out_last` is seen. After `frame_done` the state is IDLE and `busy`=0.
- **Async reset.** Assert `reset_n` low mid-RUN with no clock edge -> all outputs are 0 immediately. After release, a full N-sample fill is required again.
